ram_req_queue: RTL

RAM_REQ_QUEUE -- requirements
Module: ram_req_queue

---
 rtl/ram_ctrl_pkg.sv | 21 ++
 rtl/req_fifo.sv | 53 +++++
 rtl/ram_req_queue.sv | 106 ++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM request queue: word geometry, FSM states and the
// queued request record.
package ram_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO. The caller guarantees push only when not full and
// pop only when not empty.
module req_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W:0]   count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  assign head  = mem[head_ptr];
  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ram_req_queue.sv
// Request queue in front of a 512x16 word RAM: buffers write/read requests
// and executes them in order, returning read data with a valid/ready handshake.
module ram_req_queue
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  state_t            state;
  state_t            state_nxt;
  req_t              head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_in_nxt;
  logic              mem_load_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;

  assign req_ready = !full;
  assign push      = req_valid && !full;

  req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ('{we: req_we, addr: req_addr, wdata: req_wdata}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_in_nxt    = mem_in;
    mem_load_nxt  = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          mem_addr_nxt = head.addr;
          mem_in_nxt   = head.wdata;
          mem_load_nxt = head.we;
          state_nxt    = head.we ? WRITE : READ;
        end
      end
      WRITE: state_nxt = IDLE;
      READ: begin
        rsp_rdata_nxt = mem_out;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        // Response is held until the consumer takes it.
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_in    <= '0;
      mem_load  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_in    <= mem_in_nxt;
      mem_load  <= mem_load_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule
